// File: rtl/load_store_unit.sv
// Load/store unit: validates a decoded memory request, runs one word-aligned
// bus transaction with a wait timeout, and returns the extended load result.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request; illegal requests raise err next cycle
// ACCESS | bus_valid held with stable address/data until bus_ready
// DONE   | one-cycle done pulse, load_data valid
module load_store_unit #(
    parameter int BUS_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_width,
    input  logic        load_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        err,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam int CNT_W = (BUS_TIMEOUT > 2) ? $clog2(BUS_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;
    logic             op_we;
    logic             op_unsigned;
    logic [1:0]       op_width;
    logic [1:0]       op_lo;
    logic [29:0]      op_word;
    logic [31:0]      op_wdata;
    logic [3:0]       op_wstrb;
    logic [31:0]      load_q;

    logic             aligned;
    logic             legal;
    logic [31:0]      lane_wdata;
    logic [3:0]       lane_wstrb;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      rd_ext;

    // Width 11 never counts as aligned, so it is rejected here as well.
    always_comb begin
        aligned = 1'b0;
        case (mem_width)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    assign legal = req_valid & (mem_read ^ mem_write) & aligned;

    always_comb begin
        lane_wdata = 32'h0;
        lane_wstrb = 4'b0000;
        if (mem_write) begin
            case (mem_width)
                2'b00: begin
                    lane_wdata = {4{store_data[7:0]}};
                    lane_wstrb = 4'b0001 << addr[1:0];
                end
                2'b01: begin
                    lane_wdata = {2{store_data[15:0]}};
                    lane_wstrb = 4'b0011 << addr[1:0];
                end
                default: begin
                    lane_wdata = store_data;
                    lane_wstrb = 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        rd_byte = bus_rdata[{op_lo, 3'b000} +: 8];
        rd_half = bus_rdata[{op_lo[1], 4'b0000} +: 16];
        case (op_width)
            2'b00:   rd_ext = op_unsigned ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   rd_ext = op_unsigned ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: rd_ext = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            err_q       <= 1'b0;
            op_we       <= 1'b0;
            op_unsigned <= 1'b0;
            op_width    <= 2'b00;
            op_lo       <= 2'b00;
            op_word     <= 30'h0;
            op_wdata    <= 32'h0;
            op_wstrb    <= 4'b0000;
            load_q      <= 32'h0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (legal) begin
                        state       <= ST_ACCESS;
                        wait_cnt    <= '0;
                        op_we       <= mem_write;
                        op_unsigned <= load_unsigned;
                        op_width    <= mem_width;
                        op_lo       <= addr[1:0];
                        op_word     <= addr[31:2];
                        op_wdata    <= lane_wdata;
                        op_wstrb    <= lane_wstrb;
                    end else if (req_valid) begin
                        err_q <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    // A ready in the final wait cycle still completes the access.
                    if (bus_ready) begin
                        state  <= ST_DONE;
                        load_q <= op_we ? 32'h0 : rd_ext;
                    end else if (wait_cnt == CNT_LAST) begin
                        state <= ST_IDLE;
                        err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus_valid = (state == ST_ACCESS);
    assign bus_we    = bus_valid & op_we;
    assign bus_addr  = bus_valid ? {op_word, 2'b00} : 32'h0;
    assign bus_wdata = bus_valid ? op_wdata : 32'h0;
    assign bus_wstrb = bus_valid ? op_wstrb : 4'b0000;

    // Gated by rst so the combinational stall drops as soon as reset asserts.
    assign busy      = rst & (((state == ST_IDLE) & legal) | bus_valid);
    assign done      = (state == ST_DONE);
    assign load_data = done ? load_q : 32'h0;
    assign err       = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-lane arithmetic model.
module tb_load_store_unit;

    localparam int BUS_T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_width;
    logic        load_unsigned;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        err;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int tests_run = 0;
    int tests_failed = 0;

    load_store_unit #(.BUS_TIMEOUT(BUS_T)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .mem_read(mem_read),
        .mem_write(mem_write), .mem_width(mem_width), .load_unsigned(load_unsigned),
        .addr(addr), .store_data(store_data), .busy(busy), .done(done),
        .load_data(load_data), .err(err), .bus_valid(bus_valid), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int size_of(input logic [1:0] w);
        return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] w, input logic uns,
                                             input logic [1:0] lo, input logic [31:0] rd);
        int sz = size_of(w);
        logic [31:0] v;
        logic [31:0] mask;
        v = rd >> (8 * lo);
        if (sz == 4) return v;
        mask = (32'h1 << (8 * sz)) - 32'h1;
        v = v & mask;
        if (!uns && ((v >> (8 * sz - 1)) & 32'h1) != 32'h0) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] w, input logic [31:0] sd);
        int sz = size_of(w);
        logic [31:0] wd;
        for (int i = 0; i < 4; i++) wd[8*i +: 8] = sd[8*(i % sz) +: 8];
        return wd;
    endfunction

    function automatic logic [3:0] exp_wstrb(input logic [1:0] w, input logic [1:0] lo);
        int sz = size_of(w);
        return 4'(((1 << sz) - 1) << lo);
    endfunction

    task automatic idle_inputs();
        req_valid = 1'b0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        mem_width = 2'b00;
        load_unsigned = 1'b0;
        addr = 32'h0;
        store_data = 32'h0;
    endtask

    // One request from its IDLE cycle through DONE, timeout or error; dly is
    // the number of ACCESS cycles bus_ready stays low.
    task automatic do_op(input logic rd, input logic wr, input logic [1:0] w, input logic uns,
                         input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                         input int dly, input logic req_in_done);
        int sz;
        logic legal;
        logic hs;
        sz = size_of(w);
        legal = (rd != wr) && (w != 2'b11) && ((int'(a[1:0]) % sz) == 0);
        @(negedge clk);
        req_valid = 1'b1; mem_read = rd; mem_write = wr; mem_width = w;
        load_unsigned = uns; addr = a; store_data = sd;
        bus_ready = 1'($urandom); bus_rdata = $urandom;
        #1;
        check("busy_req", busy, legal);
        check("valid_req", bus_valid, 1'b0);
        @(negedge clk);
        req_valid = 1'b0; mem_read = 1'($urandom); mem_write = 1'($urandom);
        mem_width = 2'($urandom); load_unsigned = 1'($urandom);
        addr = $urandom; store_data = $urandom;
        if (!legal) begin
            #1;
            check("ill_err", err, 1'b1);
            check("ill_busy", busy, 1'b0);
            check("ill_valid", bus_valid, 1'b0);
            @(negedge clk);
            #1;
            check("ill_err_clr", err, 1'b0);
            check("ill_valid2", bus_valid, 1'b0);
            return;
        end
        hs = 1'b0;
        for (int k = 0; k < BUS_T; k++) begin
            bus_ready = (k >= dly);
            bus_rdata = rdat;
            #1;
            check("acc_valid", bus_valid, 1'b1);
            check("acc_busy", busy, 1'b1);
            check("acc_addr", bus_addr, {a[31:2], 2'b00});
            check("acc_we", bus_we, wr);
            check("acc_wstrb", bus_wstrb, wr ? exp_wstrb(w, a[1:0]) : 4'b0000);
            if (wr) check("acc_wdata", bus_wdata, exp_wdata(w, sd));
            check("acc_err", err, 1'b0);
            check("acc_done", done, 1'b0);
            @(negedge clk);
            if (k >= dly) begin
                hs = 1'b1;
                break;
            end
        end
        bus_rdata = $urandom;
        bus_ready = 1'($urandom);
        if (hs) begin
            if (req_in_done) begin
                req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
                mem_width = 2'b10; addr = 32'h0000_0400;
            end
            #1;
            check("done", done, 1'b1);
            check("load_data", load_data, wr ? 32'h0 : exp_load(w, uns, a[1:0], rdat));
            check("done_busy", busy, 1'b0);
            check("done_valid", bus_valid, 1'b0);
            check("done_err", err, 1'b0);
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            check("post_done", done, 1'b0);
            check("post_valid", bus_valid, 1'b0);
            check("post_load", load_data, 32'h0);
            check("post_err", err, 1'b0);
        end else begin
            #1;
            check("to_err", err, 1'b1);
            check("to_done", done, 1'b0);
            check("to_valid", bus_valid, 1'b0);
            check("to_busy", busy, 1'b0);
            @(negedge clk);
            #1;
            check("to_err_clr", err, 1'b0);
            check("to_done2", done, 1'b0);
        end
    endtask

    initial begin
        logic        rd, wr, uns, rdn;
        logic [1:0]  w;
        logic [31:0] a;
        int          r;

        rst = 1'b0;
        idle_inputs();
        bus_ready = 1'b1;
        bus_rdata = 32'h0;
        req_valid = 1'b1; mem_read = 1'b1; mem_width = 2'b10; addr = 32'h0000_0010;
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_valid", bus_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_load", load_data, 32'h0);
        check("rst_we", bus_we, 1'b0);
        check("rst_addr", bus_addr, 32'h0);
        check("rst_wdata", bus_wdata, 32'h0);
        check("rst_wstrb", bus_wstrb, 4'b0000);
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;

        do_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 0, 1'b0);
        do_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 0, 1'b0);
        do_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_BEEF, 32'h1234_5678, 0, 1'b1);
        do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 32'h0, 0, 1'b0);
        do_op(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'h0, 0, 1'b0);
        do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 100, 1'b0);
        do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, BUS_T - 1, 1'b0);

        // Reset in the middle of an access.
        @(negedge clk);
        req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_width = 2'b10;
        addr = 32'h0000_0040; bus_ready = 1'b0;
        @(negedge clk);
        idle_inputs();
        #1;
        check("mid_valid_pre", bus_valid, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        check("mid_valid", bus_valid, 1'b0);
        check("mid_busy", busy, 1'b0);
        check("mid_addr", bus_addr, 32'h0);
        bus_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("mid_no_done", done, 1'b0);
            check("mid_no_valid", bus_valid, 1'b0);
        end
        do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0044, 32'h0, 32'h0BAD_CAFE, 1, 1'b0);

        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin rd = 1'b1; wr = 1'b1; end
            else if (r == 1) begin rd = 1'b0; wr = 1'b0; end
            else begin rd = 1'($urandom); wr = ~rd; end
            w = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (w == 2'b01) a[0] = 1'b0;
                if (w[1]) a[1:0] = 2'b00;
            end
            uns = 1'($urandom);
            do_op(rd, wr, w, uns, a, $urandom, $urandom, $urandom_range(0, BUS_T + 1),
                  1'($urandom));
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                rdn = 1'($urandom);
                req_valid = 1'b0; mem_read = rdn; mem_write = ~rdn;
                bus_ready = 1'($urandom);
                #1;
                check("idle_busy", busy, 1'b0);
                check("idle_valid", bus_valid, 1'b0);
                @(negedge clk);
                #1;
                check("idle_err", err, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
